pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised successor to the fixed-field inter-stage pipeline registers.
//  Carries an opaque payload plus a control vector through a DEPTH-entry elastic
//  buffer with valid/ready handshake. Replaces the global stall input with backpressure.
//  Adds a synchronous flush, and clears control bits on bubbles so that stalled or
//  empty slots never assert we/ld/str downstream.
//  Instantiated between EX and MEM, and reusable between any two stages.
// PARAMETERS
//  DATA_W  32  payload width (alu_out, b2, a2, link_addr, rd ... concatenated by parent)
//  CTRL_W  8   control width (we, ld, str, byt, taken, link_we ...); forced 0 on bubble
//  DEPTH   2   buffer entries, legal 1..4; 2 gives full throughput with registered in_ready
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 asynchronous reset, active-low
//  in_valid   in   1                 upstream holds valid beat
//  in_ready   out  1                 buffer can accept; registered, no comb path from out_ready
//  in_data    in   DATA_W            upstream payload
//  in_ctrl    in   CTRL_W            upstream control bits
//  flush      in   1                 synchronous discard of all held beats
//  out_valid  out  1                 head entry valid
//  out_ready  in   1                 downstream accepts head
//  out_data   out  DATA_W            head payload
//  out_ctrl   out  CTRL_W            head control; 0 whenever out_valid=0
//  count      out  $clog2(DEPTH+1)   occupied entries
// BEHAVIOUR
//  - Reset (rst=0, async): count=0, rd/wr ptr=0, all storage=0.
//    Outputs: in_ready=1, out_valid=0, out_data=0, out_ctrl=0. Takes effect mid-transfer.
//    In-flight beats are lost.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both sampled at posedge clk.
//  - push writes mem[wr_ptr], wr_ptr++; pop advances rd_ptr++.
//    Pointers wrap modulo DEPTH (DEPTH need not be a power of 2).
//  - count' = count + push - pop; push & pop in the same cycle leaves count unchanged.
//  - Latency: beat pushed at edge N is visible on out_* after edge N (1 cycle),
//    independent of occupancy when empty.
//  - out_valid = (count!=0); out_data = mem[rd_ptr]; out_ctrl = out_valid ? ctrl[rd_ptr] : 0.
//  - in_ready registered: next value = (count' < DEPTH), computed from the next state.
//    When full, in_ready=0 even if out_ready=1 that cycle; it rises the cycle after the pop.
//  - DEPTH=1: alternates accept/release, 50% max throughput (documented, legal).
//  - Full: in_valid held with in_ready=0; upstream must keep in_data/in_ctrl stable (no push).
//  - Empty: out_ready ignored; no pop, no underflow.
//  - flush=1 (highest priority):
//    - next state count=0, ptrs=0, in_ready=1.
//    - A concurrent push or pop is discarded.
//    - Storage contents need not be cleared; out_ctrl is masked by out_valid.
//  - in_valid may drop without a handshake (stage squash); no beat is recorded.
//  - No X propagation: out_ctrl is a hard 0 when empty regardless of storage.
// CONFIGURATION
//  PIPE_STAGE_BUF_STATS_EN defined:
//    - Adds outputs stall_cnt[31:0] (cycles with in_valid & !in_ready) and
//      bubble_cnt[31:0] (cycles with !out_valid & out_ready).
//    - Both counters saturate at 32'hFFFF_FFFF, reset to 0 on rst, and are not
//      cleared by flush.
//  Not defined: those ports and counters do not exist; core behaviour identical.
// TESTING
//  1. Reset: rst=0 mid-stream with count=2 -> immediately out_valid=0, out_ctrl=0,
//     in_ready=1, count=0.
//  2. DEPTH=2 streaming: in_valid=1 and out_ready=1 for 10 cycles, data 0..9 ->
//     out_data 0..9 in order, one per cycle from cycle 1, count stays 1.
//  3. Backpressure: out_ready=0, push A=0x11, B=0x22 -> count=2, in_ready=0, C held.
//     Then out_ready=1 -> A, B, C emitted in order, none lost or duplicated.
//  4. Bubble masking: push in_ctrl=8'hFF then idle -> out_ctrl=8'hFF for one beat,
//     then 8'h00 with out_valid=0.
//  5. Flush with push: count=2, flush=1 and in_valid=1 (D=0x33) -> next cycle
//     count=0, out_valid=0, 0x33 never appears.
//  6. STATS_EN: hold in_valid=1, out_ready=0 for 5 cycles at DEPTH=2 ->
//     stall_cnt=3; with the macro undefined the build has no stall_cnt port.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage register: DEPTH-entry buffer with valid/ready handshake, synchronous flush
// and control masking on bubbles. Define PIPE_STAGE_BUF_STATS_EN to add stall/bubble counters.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    // Handshake: a beat moves on a rising edge only when valid and ready are both high
    // in the cycle before it; ready never depends combinationally on valid.
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [CTRL_W-1:0] r_mem_ctrl [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_in_ready;

    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;
    logic [PTR_W-1:0]  w_wr_nxt;
    logic [PTR_W-1:0]  w_rd_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_in_ready_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Flush wins over any concurrent push or pop.
    always_comb begin
        w_wr_nxt    = r_wr_ptr;
        w_rd_nxt    = r_rd_ptr;
        w_count_nxt = r_count;
        if (flush) begin
            w_wr_nxt    = '0;
            w_rd_nxt    = '0;
            w_count_nxt = '0;
        end else begin
            if (w_push) w_wr_nxt = ptr_inc(r_wr_ptr);
            if (w_pop)  w_rd_nxt = ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    assign w_in_ready_nxt = (w_count_nxt < DEPTH_C);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_count    <= w_count_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_ctrl[i] <= '0;
            end
        end else if (w_push && !flush) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_ctrl[r_wr_ptr] <= in_ctrl;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_mem_data[r_rd_ptr];
    // Stale storage must never leak control bits downstream.
    assign out_ctrl  = w_out_valid ? r_mem_ctrl[r_rd_ptr] : '0;
    assign count     = r_count;

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !r_in_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!w_out_valid && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf (DEPTH=2): queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  count;
`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0]       stall_cnt;
    logic [31:0]       bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count)
`ifdef PIPE_STAGE_BUF_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    // Clock / reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is just an ordered list of {ctrl,data} beats.
    logic [CTRL_W+DATA_W-1:0] mq[$];
    logic [CTRL_W+DATA_W-1:0] drop;
    bit m_push, m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) drop = mq.pop_front();
                if (m_push) mq.push_back({in_ctrl, in_data});
            end
        end
    end

    // Scoreboard: compare on every falling edge; log accepted output beats.
    logic [DATA_W-1:0] got_q[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            check("count", 64'(count), 64'(mq.size()));
            if (mq.size() != 0) begin
                check("out_data", 64'(out_data), 64'(mq[0][DATA_W-1:0]));
                check("out_ctrl", 64'(out_ctrl), 64'(mq[0][CTRL_W+DATA_W-1:DATA_W]));
            end else begin
                check("out_ctrl_bubble", 64'(out_ctrl), 64'(0));
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
        end
    end

    // Driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accept();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        check("accept_timeout", 64'(done), 64'(1));
    endtask

    task automatic compare_log(input string name);
        check({name, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(name, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        step(3);
        rst = 1'b1;
        step(1);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_count", 64'(count), 64'(0));

        // Hold a beat against a blocked sink: two pushes, then three stall cycles.
        in_valid = 1'b1; in_data = 32'hA1; in_ctrl = 8'h01; out_ready = 1'b0;
        step(5);
        check("fill_count", 64'(count), 64'(2));
        check("fill_in_ready", 64'(in_ready), 64'(0));
`ifdef PIPE_STAGE_BUF_STATS_EN
        check("stall_cnt", 64'(stall_cnt), 64'(3));
`endif

        // Asynchronous reset while holding two beats, asserted between edges.
        #3 rst = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'(0));
        check("async_out_ctrl", 64'(out_ctrl), 64'(0));
        check("async_in_ready", 64'(in_ready), 64'(1));
        check("async_count", 64'(count), 64'(0));
        in_valid = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);

        // Streaming: ten beats back to back, occupancy steady at one.
        got_q.delete(); exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(i + 1);
            step(1);
            if (i == 5) check("stream_count", 64'(count), 64'(1));
        end
        in_valid = 1'b0;
        step(2);
        for (int i = 0; i < 10; i++) exp_q.push_back(DATA_W'(i));
        compare_log("stream");

        // Backpressure: A and B fill the buffer, C waits until space frees.
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h03;
        step(1);
        in_data = 32'h22; in_ctrl = 8'h05;
        step(1);
        in_data = 32'h44; in_ctrl = 8'h09;
        step(3);
        check("bp_count", 64'(count), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        wait_accept();
        in_valid = 1'b0;
        step(4);
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h44);
        compare_log("backpressure");

        // Bubble masking of control bits.
        in_valid = 1'b1; in_data = 32'hBEEF; in_ctrl = 8'hFF;
        step(1);
        in_valid = 1'b0;
        check("mask_valid_beat", 64'(out_valid), 64'(1));
        check("mask_ctrl_beat", 64'(out_ctrl), 64'(8'hFF));
        step(1);
        check("mask_valid_idle", 64'(out_valid), 64'(0));
        check("mask_ctrl_idle", 64'(out_ctrl), 64'(8'h00));

        // Flush with a full buffer and an offered beat, then with a live push.
        got_q.delete(); exp_q.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 8'h11;
        step(1);
        in_data = 32'h66; in_ctrl = 8'h12;
        step(1);
        check("flush_pre_count", 64'(count), 64'(2));
        flush = 1'b1; in_data = 32'h33; in_ctrl = 8'h13;
        step(1);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", 64'(count), 64'(0));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        in_valid = 1'b1; in_data = 32'h77; in_ctrl = 8'h14;
        step(1);
        flush = 1'b1; in_data = 32'h33; in_ctrl = 8'h15;
        step(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_push_count", 64'(count), 64'(0));
        step(3);
        compare_log("flush_drop");

        // Mixed traffic; the model checks every cycle.
        for (int i = 0; i < 80; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = DATA_W'($urandom);
            in_ctrl   = CTRL_W'($urandom_range(0, 255));
            step(1);
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(3);
        check("drain_count", 64'(count), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
